// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline definitions: operand-select and FSM encodings, the
// tracking-entry record, and the source-match rule used by the forwarding logic.
package forwarding_hazard_unit_pkg;

   // Entries store destinations zero-extended to this width so that the record
   // type stays independent of the AW chosen by each instance.
   localparam int RD_W_MAX = 8;

   typedef enum logic [1:0] {
      SEL_RF    = 2'b00,
      SEL_EXMEM = 2'b10,
      SEL_MEMWB = 2'b01,
      SEL_WBBYP = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LU_STALL = 2'b01,
      ST_MEM_HOLD = 2'b10
   } state_e;

   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      logic                wr;
      logic                load;
   } entry_t;

   // r0 is hardwired, so it never produces a dependency.
   function automatic logic src_match(entry_t e, logic [RD_W_MAX-1:0] src, logic use_src);
      return e.valid && e.wr && use_src && (src != '0) && (e.rd == src);
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage request, pipeline control and hazard/forwarding results between
// the pipeline (master) and the hazard unit (slave).
interface forwarding_hazard_unit_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_use_rs;
   logic          id_use_rt;
   logic [AW-1:0] id_rd;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          flush;
   logic          mem_wait;
   logic          cnt_clr;
   logic             stall_id;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
             id_reg_write, id_mem_read, flush, mem_wait, cnt_clr,
      input  stall_id, fwd_a, fwd_b, state, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
             id_reg_write, id_mem_read, flush, mem_wait, cnt_clr,
      output stall_id, fwd_a, fwd_b, state, stall_cnt
   );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_match.sv
// Compares one ID source against the EX/MEM/WB tracking entries and returns
// the operand select of the youngest matching producer.
module fwd_match
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int RF_WRITE_THROUGH = 1
) (
   input  entry_t              ex_i,
   input  entry_t              mem_i,
   input  entry_t              wb_i,
   input  logic [RD_W_MAX-1:0] src_i,
   input  logic                use_i,
   output fwd_sel_e            sel_o
);

   always_comb begin
      sel_o = SEL_RF;
      if (src_match(ex_i, src_i, use_i)) begin
         sel_o = SEL_EXMEM;
      end else if (src_match(mem_i, src_i, use_i)) begin
         sel_o = SEL_MEMWB;
      end else if ((RF_WRITE_THROUGH == 0) && src_match(wb_i, src_i, use_i)) begin
         // Without write-through the regfile read misses the WB write, so the
         // value comes from the bypass latch instead.
         sel_o = SEL_WBBYP;
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Load-use hazard detection and EX operand forwarding for a 5-stage pipeline,
// with a stall counter and a RUN/LU_STALL/MEM_HOLD status FSM.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int AW               = 5,
   parameter int RF_WRITE_THROUGH = 1,
   parameter int CNT_W            = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   forwarding_hazard_unit_if.slave bus
);

   entry_t             ex_q, mem_q, wb_q;
   entry_t             ex_d, mem_d, wb_d;
   fwd_sel_e           fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
   fwd_sel_e           sel_a, sel_b;
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [AW-1:0]       rs_a, rt_a, rd_a;
   logic [RD_W_MAX-1:0] rs_x, rt_x, rd_x;
   logic                stall;
   logic                bubble;

   assign rs_a = bus.id_rs;
   assign rt_a = bus.id_rt;
   assign rd_a = bus.id_rd;
   assign rs_x = RD_W_MAX'(rs_a);
   assign rt_x = RD_W_MAX'(rt_a);
   assign rd_x = RD_W_MAX'(rd_a);

   // A consumer directly behind a load cannot be forwarded in time.
   assign stall = bus.id_valid && !bus.flush && ex_q.load &&
                  (src_match(ex_q, rs_x, bus.id_use_rs) ||
                   src_match(ex_q, rt_x, bus.id_use_rt));
   assign bubble = bus.flush || stall;

   fwd_match #(.RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_match_rs (
      .ex_i  (ex_q),
      .mem_i (mem_q),
      .wb_i  (wb_q),
      .src_i (rs_x),
      .use_i (bus.id_use_rs),
      .sel_o (sel_a)
   );

   fwd_match #(.RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_match_rt (
      .ex_i  (ex_q),
      .mem_i (mem_q),
      .wb_i  (wb_q),
      .src_i (rt_x),
      .use_i (bus.id_use_rt),
      .sel_o (sel_b)
   );

   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      wb_d    = wb_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      cnt_d   = cnt_q;
      if (!bus.mem_wait) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (bubble) begin
            ex_d    = '0;
            fwd_a_d = SEL_RF;
            fwd_b_d = SEL_RF;
         end else begin
            ex_d.valid = bus.id_valid;
            ex_d.rd    = rd_x;
            ex_d.wr    = bus.id_reg_write;
            ex_d.load  = bus.id_mem_read;
            fwd_a_d    = sel_a;
            fwd_b_d    = sel_b;
         end
         if (bus.cnt_clr) begin
            cnt_d = '0;
         end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = ST_RUN;
      if (bus.mem_wait) begin
         state_d = ST_MEM_HOLD;
      end else if (stall) begin
         state_d = ST_LU_STALL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         fwd_a_q <= SEL_RF;
         fwd_b_q <= SEL_RF;
         cnt_q   <= '0;
         state_q <= ST_RUN;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign bus.stall_id  = stall;
   assign bus.fwd_a     = fwd_a_q;
   assign bus.fwd_b     = fwd_b_q;
   assign bus.state     = state_q;
   assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed hazard scenarios plus random
// traffic, both checked against an instruction-level pipeline model.
module tb_forwarding_hazard_unit;

   logic clk;
   logic rst_n;

   logic       t_valid, t_urs, t_urt, t_wr, t_ld, t_fl, t_mw, t_clr;
   logic [4:0] t_rs, t_rt, t_rd;

   forwarding_hazard_unit_if #(.AW(5), .CNT_W(16)) bus1 ();
   forwarding_hazard_unit_if #(.AW(5), .CNT_W(3))  bus0 ();

   assign bus1.id_valid = t_valid;  assign bus0.id_valid = t_valid;
   assign bus1.id_rs = t_rs;        assign bus0.id_rs = t_rs;
   assign bus1.id_rt = t_rt;        assign bus0.id_rt = t_rt;
   assign bus1.id_use_rs = t_urs;   assign bus0.id_use_rs = t_urs;
   assign bus1.id_use_rt = t_urt;   assign bus0.id_use_rt = t_urt;
   assign bus1.id_rd = t_rd;        assign bus0.id_rd = t_rd;
   assign bus1.id_reg_write = t_wr; assign bus0.id_reg_write = t_wr;
   assign bus1.id_mem_read = t_ld;  assign bus0.id_mem_read = t_ld;
   assign bus1.flush = t_fl;        assign bus0.flush = t_fl;
   assign bus1.mem_wait = t_mw;     assign bus0.mem_wait = t_mw;
   assign bus1.cnt_clr = t_clr;     assign bus0.cnt_clr = t_clr;

   forwarding_hazard_unit #(.AW(5), .RF_WRITE_THROUGH(1), .CNT_W(16)) dut_wt (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   forwarding_hazard_unit #(.AW(5), .RF_WRITE_THROUGH(0), .CNT_W(3)) dut_nwt (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Model: in-flight instructions indexed by distance ahead of ID (0=EX,1=MEM,2=WB).
   typedef struct {bit valid; int rd; bit wr; bit load;} ins_t;
   ins_t pipe[3];
   int   m_fa1, m_fb1, m_fa0, m_fb0, m_state, m_cnt1, m_cnt0;
   bit   last_stall;

   function automatic bit depends(ins_t p, int src, bit use_src);
      return p.valid && p.wr && use_src && src != 0 && p.rd == src;
   endfunction

   function automatic bit m_stall();
      return t_valid && !t_fl && pipe[0].load &&
             (depends(pipe[0], t_rs, t_urs) || depends(pipe[0], t_rt, t_urt));
   endfunction

   // Select of the nearest producer: EX/MEM=2, MEM/WB=1, WB latch=3 (or regfile when written through).
   function automatic int m_sel(int src, bit use_src, bit wt);
      for (int k = 0; k < 3; k++) begin
         if (depends(pipe[k], src, use_src)) begin
            if (k == 0) return 2;
            if (k == 1) return 1;
            return wt ? 0 : 3;
         end
      end
      return 0;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
      m_fa1 = 0; m_fb1 = 0; m_fa0 = 0; m_fb0 = 0;
      m_state = 0; m_cnt1 = 0; m_cnt0 = 0;
   endtask

   task automatic m_step();
      bit st, bub;
      if (t_mw) begin
         m_state = 2;
         return;
      end
      st  = m_stall();
      bub = t_fl || st;
      m_fa1 = bub ? 0 : m_sel(t_rs, t_urs, 1);
      m_fb1 = bub ? 0 : m_sel(t_rt, t_urt, 1);
      m_fa0 = bub ? 0 : m_sel(t_rs, t_urs, 0);
      m_fb0 = bub ? 0 : m_sel(t_rt, t_urt, 0);
      if (t_clr) begin
         m_cnt1 = 0; m_cnt0 = 0;
      end else if (st) begin
         if (m_cnt1 < 65535) m_cnt1++;
         if (m_cnt0 < 7) m_cnt0++;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = bub ? '{0, 0, 0, 0} : '{t_valid, t_rd, t_wr, t_ld};
      m_state = st ? 1 : 0;
   endtask

   task automatic check_regs();
      check_eq("fwd_a_wt", bus1.fwd_a, m_fa1);
      check_eq("fwd_b_wt", bus1.fwd_b, m_fb1);
      check_eq("fwd_a_nwt", bus0.fwd_a, m_fa0);
      check_eq("fwd_b_nwt", bus0.fwd_b, m_fb0);
      check_eq("state", bus1.state, m_state);
      check_eq("state_nwt", bus0.state, m_state);
      check_eq("cnt_wt", bus1.stall_cnt, m_cnt1);
      check_eq("cnt_nwt", bus0.stall_cnt, m_cnt0);
   endtask

   task automatic cyc(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int rd, input bit wr, input bit ld,
                      input bit fl, input bit mw, input bit clr);
      @(negedge clk);
      t_valid = v; t_rs = 5'(rs); t_rt = 5'(rt); t_urs = urs; t_urt = urt;
      t_rd = 5'(rd); t_wr = wr; t_ld = ld; t_fl = fl; t_mw = mw; t_clr = clr;
      #1;
      last_stall = bus1.stall_id;
      check_eq("stall_wt", bus1.stall_id, m_stall());
      check_eq("stall_nwt", bus0.stall_id, m_stall());
      @(posedge clk);
      m_step();
      #1;
      check_regs();
   endtask

   task automatic nop();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   int c0;

   initial begin
      rst_n = 1'b0;
      t_valid = 0; t_rs = 0; t_rt = 0; t_urs = 0; t_urt = 0;
      t_rd = 0; t_wr = 0; t_ld = 0; t_fl = 0; t_mw = 0; t_clr = 0;
      m_reset();
      #1;
      check_regs();
      check_eq("reset_stall", bus1.stall_id, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU producer then consumer
      cyc(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
      cyc(1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0);
      check_eq("alu_fwd_a", bus1.fwd_a, 2);
      check_eq("alu_nostall", last_stall, 0);

      // load-use on rt
      nop(); nop(); nop();
      cyc(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
      cyc(1, 1, 5, 1, 1, 8, 1, 0, 0, 0, 0);
      check_eq("lu_stall", last_stall, 1);
      check_eq("lu_cnt", bus1.stall_cnt, 1);
      check_eq("lu_state", bus1.state, 1);
      cyc(1, 1, 5, 1, 1, 8, 1, 0, 0, 0, 0);
      check_eq("lu_reissue_stall", last_stall, 0);
      check_eq("lu_fwd_b", bus1.fwd_b, 1);

      // r0 never forwards
      cyc(1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0);
      cyc(1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0);
      check_eq("r0_stall", last_stall, 0);
      check_eq("r0_fwd_a", bus1.fwd_a, 0);
      check_eq("r0_fwd_b", bus1.fwd_b, 0);

      // load-use held by mem_wait
      nop(); nop(); nop();
      c0 = bus1.stall_cnt;
      cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 7, 0, 1, 0, 9, 1, 0, 0, 1, 0);
         check_eq("mw_stall", last_stall, 1);
         check_eq("mw_state", bus1.state, 2);
         check_eq("mw_cnt", bus1.stall_cnt, c0);
      end
      cyc(1, 7, 0, 1, 0, 9, 1, 0, 0, 0, 0);
      check_eq("mw_rel_stall", last_stall, 1);
      check_eq("mw_rel_cnt", bus1.stall_cnt, c0 + 1);
      cyc(1, 7, 0, 1, 0, 9, 1, 0, 0, 0, 0);
      check_eq("mw_reissue_stall", last_stall, 0);
      check_eq("mw_fwd_a", bus1.fwd_a, 1);

      // producer three slots ahead
      nop(); nop(); nop();
      cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
      nop(); nop();
      cyc(1, 9, 0, 1, 0, 2, 1, 0, 0, 0, 0);
      check_eq("wb_fwd_a_nwt", bus0.fwd_a, 3);
      check_eq("wb_fwd_a_wt", bus1.fwd_a, 0);

      // flush beats stall: bubble, no count
      c0 = bus1.stall_cnt;
      cyc(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
      cyc(1, 4, 0, 1, 0, 2, 1, 0, 1, 0, 0);
      check_eq("fl_stall", last_stall, 0);
      check_eq("fl_cnt", bus1.stall_cnt, c0);
      check_eq("fl_state", bus1.state, 0);

      // counter saturation on the 3-bit instance
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("clr_cnt", bus1.stall_cnt, 0);
      for (int i = 0; i < 9; i++) begin
         cyc(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
         cyc(1, 2, 0, 1, 0, 3, 1, 0, 0, 0, 0);
         cyc(1, 2, 0, 1, 0, 3, 1, 0, 0, 0, 0);
      end
      check_eq("sat_cnt_nwt", bus0.stall_cnt, 7);
      check_eq("sat_cnt_wt", bus1.stall_cnt, 9);

      // asynchronous reset while in LU_STALL
      cyc(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
      cyc(1, 6, 0, 1, 0, 3, 1, 0, 0, 0, 0);
      check_eq("pre_rst_state", bus1.state, 1);
      rst_n = 1'b0;
      m_reset();
      #1;
      check_eq("rst_state", bus1.state, 0);
      check_eq("rst_cnt", bus1.stall_cnt, 0);
      check_eq("rst_fwd_a", bus1.fwd_a, 0);
      check_eq("rst_stall", bus1.stall_id, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      cyc(1, 6, 0, 1, 0, 3, 1, 0, 0, 0, 0);
      check_eq("post_rst_stall", last_stall, 0);
      check_eq("post_rst_state", bus1.state, 0);

      // random traffic on a small register set to provoke hazards
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(9, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0),
             $urandom_range(3, 0) != 0, $urandom_range(4, 0) < 2,
             $urandom_range(9, 0) == 0, $urandom_range(6, 0) == 0,
             $urandom_range(19, 0) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
